noc_eject_endpoint: RTL and testbench
=====================================

Name: noc_eject_endpoint

Overview:
- Destination-side ejection port of the 2x2 mesh: sinks flits from a router's local output and checks the destination ID.
- Reassembles head/body/tail packets and streams payload words to the attached processor through a small FIFO.
- Complements the processor-side configure/injection path; one instance per node (NODE_ID 0..3).

Parameters:
FLIT_W, 11, flit width; matches the processor configure word width
NODE_ID, 0, this node's 2-bit mesh ID
DEPTH, 4, payload FIFO depth (power of two, >=2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_flit  input  FLIT_W  flit from router local port
in_valid  input  1  in_flit valid
in_ready  output  1  endpoint accepts in_flit this cycle
out_data  output  FLIT_W-2  payload word
out_src  output  2  source node of the current word
out_last  output  1  word is the packet's final payload
out_valid  output  1  out_data valid
out_ready  input  1  processor consumes the word
pkt_count  output  8  packets fully accepted, wrapping
err_flags  output  3  sticky errors: [0] misroute, [1] protocol, [2] length

Behaviour:
- Flit format: [1:0] type (00 idle, 01 head, 10 body, 11 tail).
- Head fields: [3:2] dst, [5:4] src, [10:6] len, where len = number of payload flits incl. tail.
- Body/tail fields: [FLIT_W-1:2] payload.
- A transfer occurs on in_valid & in_ready. Type 00 is ignored even when valid.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_src=0, out_last=0, pkt_count=0, err_flags=0, FIFO empty, FSM=IDLE. Reset mid-packet discards all state.
- FSM state IDLE:
  - in_ready=1.
  - Head with dst==NODE_ID: latch src/len, clear rx counter, go to RECV. If len==0, stay IDLE and increment pkt_count.
  - Head with dst!=NODE_ID: set err[0], go to DROP.
  - Body/tail: discarded, set err[1].
- FSM state RECV:
  - in_ready = !fifo_full.
  - Body/tail write {last=(type==11), src, payload} into the FIFO and increment rx counter.
  - On tail: pkt_count+1, go to IDLE. If rx count incl. tail != len, set err[2].
  - Body with rx count already == len: write as normal, set err[2].
  - Head in RECV: dropped, set err[1], stay in RECV.
- FSM state DROP:
  - in_ready=1; all flits are discarded.
  - Tail returns to IDLE. Head is treated as in IDLE (re-evaluate).
- FIFO behaviour:
  - Accepted payload appears on out_valid the next cycle (1-cycle latency).
  - out_* outputs are registered FIFO head; they stay stable while out_valid & !out_ready.
  - Simultaneous push/pop when full is not allowed, because in_ready is based on full and is registered-free combinational from the count.
  - Simultaneous push/pop when non-full leaves the count unchanged.
- Counters: pkt_count wraps 255->0. The rx counter is 5 bits and saturates at 31.
- err_flags stay set until reset.

Optional Feature:
- Macro: NOC_EJECT_STATS_EN.
- Defined:
  - Adds output drop_count[7:0], which increments once per misrouted head, wraps, and resets to 0.
  - Adds output occupancy[$clog2(DEPTH):0], the live FIFO count.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Decomposition:
- Shared package noc_pkg:
  - Flit type constants FLIT_IDLE/HEAD/BODY/TAIL.
  - Field bit positions (TYPE_LSB, DST_LSB, SRC_LSB, LEN_LSB, PAYLOAD_LSB).
  - NODE_ID width constant.
  - FSM state encoding.
- One sub-module: noc_eject_fifo, a synchronous FIFO with parameterised width/depth and full/empty/count.

Test Plan:
- NODE_ID=1; head dst=1 src=2 len=2, body payload 0x055, tail 0x1AA; out_ready=1 -> out words 0x055 (last=0), then 0x1AA (last=1), both with out_src=2; pkt_count=1; err_flags=0.
- Head dst=3 to NODE_ID=1 plus body/tail -> nothing output; err[0]=1; with NOC_EJECT_STATS_EN, drop_count=1; the next valid packet is received normally.
- out_ready=0, 6-flit packet (head + 5 payload), DEPTH=4 -> in_ready drops after 4 writes; after out_ready=1, all 5 words arrive in order and stay stable while stalled.
- Head len=3 followed by a tail after 1 body -> err[2]=1; pkt_count=1; out_last set on the tail word.
- Reset asserted for 1 cycle mid-packet after 1 body -> all outputs return to reset values; a new packet is accepted and pkt_count=1.
- Head with len=0 -> no output; pkt_count increments; FSM stays IDLE; in_ready=1 every cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh ejection endpoint: flit type codes, flit field
// positions, node ID width and the receive FSM state encoding.
package noc_pkg;

  localparam int unsigned NODE_W = 2;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned LEN_W  = 5;

  localparam int unsigned TYPE_LSB    = 0;
  localparam int unsigned DST_LSB     = 2;
  localparam int unsigned SRC_LSB     = 4;
  localparam int unsigned LEN_LSB     = 6;
  localparam int unsigned PAYLOAD_LSB = 2;

  localparam logic [TYPE_W-1:0] FLIT_IDLE = 2'b00;
  localparam logic [TYPE_W-1:0] FLIT_HEAD = 2'b01;
  localparam logic [TYPE_W-1:0] FLIT_BODY = 2'b10;
  localparam logic [TYPE_W-1:0] FLIT_TAIL = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop
  } eject_state_e;

endpackage

// File: rtl/noc_eject_fifo.sv
// Synchronous FIFO holding reassembled payload words; the head entry is read
// straight from the storage registers and reads as zero while empty.
module noc_eject_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AddrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap since Depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AddrW + 1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AddrW + 1)'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/noc_eject_endpoint.sv
// Mesh ejection endpoint: checks destination IDs, reassembles head/body/tail
// packets and streams payload words to the processor through a small FIFO.
// Optional statistics ports (drop_count, occupancy) are built when the macro
// NOC_EJECT_STATS_EN is defined.
module noc_eject_endpoint
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W  = 11,
  parameter int unsigned NODE_ID = 0,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [FLIT_W-1:0]         in_flit,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [FLIT_W-3:0]         out_data,
  output logic [1:0]                out_src,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                pkt_count,
  output logic [2:0]                err_flags
`ifdef NOC_EJECT_STATS_EN
  ,
  output logic [7:0]                drop_count,
  output logic [$clog2(DEPTH):0]    occupancy
`endif
);

  localparam logic [NODE_W-1:0] NodeId = NODE_W'(NODE_ID);
  localparam int unsigned       FifoW  = FLIT_W + 1;

  eject_state_e      state_q, state_d;
  logic [NODE_W-1:0] src_q, src_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rx_q, rx_d, rx_inc;
  logic [7:0]        pkt_q, pkt_d;
  logic [2:0]        err_q, err_d;

  logic [TYPE_W-1:0] flit_type;
  logic [NODE_W-1:0] flit_dst, flit_src;
  logic [LEN_W-1:0]  flit_len;
  logic [FLIT_W-3:0] flit_payload;
  logic              xfer;
  logic              push, push_last;

  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [FifoW-1:0]      fifo_rdata;

  assign flit_type    = in_flit[TYPE_LSB +: TYPE_W];
  assign flit_dst     = in_flit[DST_LSB +: NODE_W];
  assign flit_src     = in_flit[SRC_LSB +: NODE_W];
  assign flit_len     = in_flit[LEN_LSB +: LEN_W];
  assign flit_payload = in_flit[FLIT_W-1:PAYLOAD_LSB];

  // Only the receive state can be back-pressured; reset forces not-ready.
  assign in_ready = !reset && ((state_q != StRecv) || !fifo_full);
  assign xfer     = in_valid && in_ready;
  assign rx_inc   = (rx_q == '1) ? rx_q : rx_q + LEN_W'(1);

  // Receive FSM next-state, field capture, counters and error flags.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    len_d     = len_q;
    rx_d      = rx_q;
    pkt_d     = pkt_q;
    err_d     = err_q;
    push      = 1'b0;
    push_last = 1'b0;
    if (xfer) begin
      unique case (state_q)
        StRecv: begin
          unique case (flit_type)
            FLIT_HEAD: err_d[1] = 1'b1;
            FLIT_BODY: begin
              push = 1'b1;
              rx_d = rx_inc;
              if (rx_q == len_q) err_d[2] = 1'b1;
            end
            FLIT_TAIL: begin
              push      = 1'b1;
              push_last = 1'b1;
              rx_d      = rx_inc;
              if (rx_inc != len_q) err_d[2] = 1'b1;
              pkt_d   = pkt_q + 8'd1;
              state_d = StIdle;
            end
            default: ;
          endcase
        end
        default: begin
          // Idle and drop share head handling: a head in drop is re-evaluated.
          unique case (flit_type)
            FLIT_HEAD: begin
              if (flit_dst == NodeId) begin
                src_d = flit_src;
                len_d = flit_len;
                rx_d  = '0;
                if (flit_len == '0) begin
                  pkt_d   = pkt_q + 8'd1;
                  state_d = StIdle;
                end else begin
                  state_d = StRecv;
                end
              end else begin
                err_d[0] = 1'b1;
                state_d  = StDrop;
              end
            end
            FLIT_BODY: if (state_q == StIdle) err_d[1] = 1'b1;
            FLIT_TAIL: begin
              if (state_q == StIdle) err_d[1] = 1'b1;
              else                   state_d  = StIdle;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  // Endpoint state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      len_q   <= '0;
      rx_q    <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      len_q   <= len_d;
      rx_q    <= rx_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  noc_eject_fifo #(
    .Width (FifoW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i ({push_last, src_q, flit_payload}),
    .pop_i   (out_ready && !fifo_empty),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_last  = fifo_rdata[FifoW-1];
  assign out_src   = fifo_rdata[FifoW-2 -: 2];
  assign out_data  = fifo_rdata[FLIT_W-3:0];
  assign pkt_count = pkt_q;
  assign err_flags = err_q;

`ifdef NOC_EJECT_STATS_EN
  logic [7:0] drop_q, drop_d;
  logic       misroute;

  assign misroute = xfer && (state_q != StRecv) && (flit_type == FLIT_HEAD) &&
                    (flit_dst != NodeId);

  // Misrouted-head counter, wrapping.
  always_comb begin
    drop_d = drop_q;
    if (misroute) drop_d = drop_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clock) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
  assign occupancy  = fifo_count;
`endif

endmodule

// File: tb/tb_noc_eject_endpoint.sv
// Scoreboard bench for noc_eject_endpoint (NODE_ID=1, DEPTH=4): a packet-level
// reference model queues expected payload words; a monitor checks every word
// the endpoint delivers.
`timescale 1ns/1ps
module tb_noc_eject_endpoint;

  localparam int unsigned FW    = 11;
  localparam int unsigned PW    = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NODE  = 1;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [FW-1:0] in_flit = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    pkt_count;
  logic [2:0]    err_flags;
`ifdef NOC_EJECT_STATS_EN
  logic [7:0]              drop_count;
  logic [$clog2(DEPTH):0]  occupancy;
`endif

  noc_eject_endpoint #(
    .FLIT_W  (FW),
    .NODE_ID (NODE),
    .DEPTH   (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_count (pkt_count),
    .err_flags (err_flags)
`ifdef NOC_EJECT_STATS_EN
    ,
    .drop_count (drop_count),
    .occupancy  (occupancy)
`endif
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [11:0] exp_q[$];
  logic [7:0] exp_pkt = '0;
  logic [2:0] exp_err = '0;
  logic [7:0] exp_drop = '0;
  bit         rand_ready = 1'b0;
  bit         mon_stall = 1'b0;
  logic [11:0] mon_prev = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] head(input logic [1:0] d, input logic [1:0] s,
                                         input logic [4:0] l);
    return {l, s, d, 2'b01};
  endfunction

  function automatic logic [FW-1:0] pay(input logic [1:0] t, input logic [PW-1:0] p);
    return {p, t};
  endfunction

  // Present one flit at the falling edge and hold it until accepted.
  task automatic send(input logic [FW-1:0] f);
    int n = 0;
    @(negedge clock);
    in_flit  = f;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clock);
    #2;
    out_ready = v;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clock);
  endtask

  // Payload flit for a packet addressed here: expected word queued before sending.
  task automatic word_here(input logic [1:0] src, input logic [PW-1:0] d, input bit last);
    exp_q.push_back({last, src, d});
    send(pay(last ? T_TAIL : T_BODY, d));
  endtask

  // A complete packet for this node carrying n payload flits against header len.
  task automatic good_pkt(input logic [1:0] src, input int len, input int n,
                          input bit stray_head, input bit idles);
    send(head(2'(NODE), src, 5'(len)));
    if (len == 0) begin
      exp_pkt++;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (stray_head && i == 0) begin
        send(head(2'($urandom_range(0, 3)), 2'($urandom), 5'($urandom)));
        exp_err[1] = 1'b1;
      end
      if (idles && $urandom_range(0, 2) == 0) send(pay(T_IDLE, PW'($urandom)));
      word_here(src, PW'($urandom), i == n - 1);
    end
    if (n != len) exp_err[2] = 1'b1;
    exp_pkt++;
  endtask

  task automatic bad_pkt(input logic [1:0] dst, input int n);
    send(head(dst, 2'($urandom), 5'(n)));
    exp_err[0] = 1'b1;
    exp_drop++;
    for (int i = 0; i < n; i++) send(pay((i == n - 1) ? T_TAIL : T_BODY, PW'($urandom)));
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_pkt_count"}, pkt_count, exp_pkt);
    chk({tag, "_err_flags"}, err_flags, exp_err);
`ifdef NOC_EJECT_STATS_EN
    chk({tag, "_drop_count"}, drop_count, exp_drop);
`endif
  endtask

  // Random back-pressure from the processor side when enabled.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: compares each consumed word and holds stalled words steady.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_stall = 1'b0;
      end else begin
        if (mon_stall) chk("stall_hold", {out_valid, out_last, out_src, out_data},
                           {1'b1, mon_prev});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %03h, required no output",
                     {out_last, out_src, out_data});
          end else begin
            chk("out_word", {out_last, out_src, out_data}, exp_q.pop_front());
          end
        end
        mon_stall = out_valid && !out_ready;
        mon_prev  = {out_last, out_src, out_data};
      end
    end
  end

  initial begin
    logic [1:0] d;
    int         kind;
    int         len;
    int         n;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word", {out_last, out_src, out_data}, 12'h000);
    chk_status("rst");
    @(posedge clock);
    #2;
    reset = 1'b0;
    set_ready(1'b1);

    // Basic two-word packet
    send(head(2'd1, 2'd2, 5'd2));
    word_here(2'd2, 9'h055, 1'b0);
    word_here(2'd2, 9'h1AA, 1'b1);
    exp_pkt++;
    chk_status("basic");

    // Misrouted packet, then a normal one
    bad_pkt(2'd3, 2);
    chk_status("misroute");
    good_pkt(2'd0, 2, 2, 1'b0, 1'b0);
    chk_status("after_misroute");
    wait_drain();

    // Back-pressure with a five-word packet into a four-entry FIFO
    set_ready(1'b0);
    send(head(2'd1, 2'd1, 5'd5));
    for (int i = 0; i < 4; i++) word_here(2'd1, PW'($urandom), 1'b0);
    @(negedge clock);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    fork
      begin
        repeat (3) @(posedge clock);
        #2;
        out_ready = 1'b1;
      end
      word_here(2'd1, PW'($urandom), 1'b1);
    join
    exp_pkt++;
    chk_status("backpressure");

    // Short packet: tail arrives after one body against len=3
    send(head(2'd1, 2'd0, 5'd3));
    word_here(2'd0, 9'h123, 1'b0);
    word_here(2'd0, 9'h0F0, 1'b1);
    exp_pkt++;
    exp_err[2] = 1'b1;
    chk_status("short_len");
    wait_drain();

    // One-cycle reset in the middle of a packet
    set_ready(1'b0);
    send(head(2'd1, 2'd3, 5'd4));
    word_here(2'd3, 9'h0AB, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_pkt  = '0;
    exp_err  = '0;
    exp_drop = '0;
    @(negedge clock);
    chk("midrst_in_ready", in_ready, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    chk("postrst_in_ready", in_ready, 1'b1);
    chk("postrst_out_valid", out_valid, 1'b0);
    chk("postrst_out_word", {out_last, out_src, out_data}, 12'h000);
    chk_status("postrst");
    set_ready(1'b1);
    good_pkt(2'd2, 2, 2, 1'b0, 1'b0);
    chk_status("after_reset");
    wait_drain();

    // Zero-length packet: counted, nothing delivered, never back-pressured
    good_pkt(2'd2, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("len0_in_ready", in_ready, 1'b1);
      chk("len0_out_valid", out_valid, 1'b0);
    end
    chk_status("len0");

    // Randomised traffic against the packet-level model
    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send(pay(($urandom_range(0, 1) == 0) ? T_BODY : T_TAIL, PW'($urandom)));
        exp_err[1] = 1'b1;
      end else if (kind == 1) begin
        good_pkt(2'($urandom), 0, 0, 1'b0, 1'b0);
      end else if (kind == 2) begin
        d = 2'($urandom_range(0, 2));
        if (d >= 2'd1) d = d + 2'd1;
        bad_pkt(d, $urandom_range(1, 4));
      end else begin
        len = $urandom_range(1, 6);
        n   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : len;
        good_pkt(2'($urandom), len, n, $urandom_range(0, 7) == 0, 1'b1);
      end
    end
    chk_status("random");
    rand_ready = 1'b0;
    set_ready(1'b1);
    wait_drain();
    chk("final_out_valid", out_valid, 1'b0);
    chk_status("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
